// File: rtl/req_capture_sequencer_if.sv
// Encoder and consumer-side signals of req_capture_sequencer.
// master = sequencer side, slave = encoder/consumer side.
interface req_capture_sequencer_if;
  logic [7:0] enc_in;
  logic       enc_en_n;
  logic [2:0] enc_y;
  logic       enc_done;
  logic       valid;
  logic       ready;
  logic [2:0] idx;

  modport master (
    output enc_in, enc_en_n, valid, idx,
    input  enc_y, enc_done, ready
  );

  modport slave (
    input  enc_in, enc_en_n, valid, idx,
    output enc_y, enc_done, ready
  );
endinterface

// File: rtl/req_capture_sequencer.sv
// Captures request rising edges, serves them lowest-index-first through an external
// priority encoder and a valid/ready handshake. Optional macro REQ_SYNC_EN adds a 2-flop REQ synchronizer.
module req_capture_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           req,
  input  logic                 clr,
  req_capture_sequencer_if.master bus,
  output logic                 ovf,
  output logic [CNT_W-1:0]     served_cnt
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t      state, state_next;
  logic [7:0]  req_s;
  logic [7:0]  prev;
  logic [7:0]  pending;
  logic [7:0]  rise;
  logic [7:0]  clr_mask;
  logic [2:0]  idx_q;
  logic        enc_en_n_q;
  logic        xfer;

`ifdef REQ_SYNC_EN
  logic [7:0] sync_q1, sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= req;
      sync_q2 <= sync_q1;
    end
  end

  assign req_s = sync_q2;
`else
  assign req_s = req;
`endif

  assign rise     = req_s & ~prev;
  // A flush cancels any handshake completing on the same edge.
  assign xfer     = bus.valid & bus.ready & ~clr;
  assign clr_mask = xfer ? (8'b1 << idx_q) : 8'b0;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      pending    <= '0;
      ovf        <= 1'b0;
      enc_en_n_q <= 1'b1;
      served_cnt <= '0;
    end else begin
      prev       <= req_s;
      // Set wins over clear: a rise on the bit being served keeps it pending.
      pending    <= clr ? rise : ((pending & ~clr_mask) | rise);
      ovf        <= ~clr & |(rise & pending & ~clr_mask);
      enc_en_n_q <= clr;
      if (xfer) served_cnt <= served_cnt + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: default assignment first so no path leaves state_next unassigned
  // (which would infer a latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.enc_done && !enc_en_n_q) state_next = OFFER;
      OFFER:   if (xfer)                        state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clr) state_next = IDLE;
  end

  // FSM outputs
  always_comb begin
    bus.valid = (state == OFFER);
  end

  // The offered index is frozen for the whole OFFER so the consumer sees a stable value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    idx_q <= '0;
    else if (state == IDLE && state_next == OFFER) idx_q <= bus.enc_y;
  end

  assign bus.enc_in   = pending;
  assign bus.enc_en_n = enc_en_n_q;
  assign bus.idx      = idx_q;

endmodule
